// File: rtl/bram_access_arbiter.sv
// Frame BRAM arbiter: one single-port BRAM shared by the AXI-Lite register path and the VGA
// pixel reader. Read returns carry a tag so each datum goes back to the side that asked for it.
module bram_access_arbiter #(
   parameter int ADDR_W     = 17,
   parameter int DATA_W     = 8,
   parameter int RD_LAT     = 1,
   parameter int ARB_MODE   = 1,
   parameter int STARVE_MAX = 16
) (
   input  logic              i_CLK,
   input  logic              i_RSTn,
   input  logic              i_SEL,
   input  logic              i_AXI_RD,
   input  logic              i_AXI_WR,
   input  logic [ADDR_W-1:0] i_AXI_ADDR,
   input  logic [DATA_W-1:0] i_AXI_WDATA,
   output logic              o_AXI_BUSY,
   output logic [DATA_W-1:0] o_AXI_RDATA,
   output logic              o_AXI_RVALID,
   output logic              o_AXI_WDONE,
   input  logic              i_VGA_RD,
   input  logic [ADDR_W-1:0] i_VGA_ADDR,
   output logic [DATA_W-1:0] o_VGA_RDATA,
   output logic              o_VGA_RVALID,
   output logic              o_VGA_MISS,
   output logic              o_BRAM_RD,
   output logic              o_BRAM_WR,
   output logic [ADDR_W-1:0] o_BRAM_ADDR,
   output logic [DATA_W-1:0] o_BRAM_WDATA,
   input  logic [DATA_W-1:0] i_BRAM_RDATA
);

   localparam int               CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
   localparam logic             DYN        = (ARB_MODE != 0);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == STARVE_LIM) ? v : v + 1'b1;
   endfunction

   logic              hold_vld_p0;
   logic              hold_wr_p0;
   logic [ADDR_W-1:0] hold_addr_p0;
   logic [DATA_W-1:0] hold_wdata_p0;
   logic [CNT_W-1:0]  starve_cnt;
   logic [CNT_W-1:0]  starve_nxt;
   logic              accept;
   logic              axi_issue;
   logic              vga_issue;
   logic              vga_zero;

   // per-stage return tags: real AXI read, VGA return, VGA return forced to zero
   logic [RD_LAT:0]   vld_axi_p;
   logic [RD_LAT:0]   vld_vga_p;
   logic [RD_LAT:0]   zero_vga_p;

   assign o_AXI_BUSY = hold_vld_p0;
   assign accept     = (i_AXI_RD | i_AXI_WR) & ~hold_vld_p0;

   always_comb begin
      axi_issue  = 1'b0;
      vga_issue  = 1'b0;
      vga_zero   = 1'b0;
      starve_nxt = starve_cnt;
      if (!DYN) begin
         if (i_SEL) begin
            vga_issue = i_VGA_RD;
         end else begin
            axi_issue = hold_vld_p0;
            vga_zero  = i_VGA_RD;
         end
      end else begin
         if (hold_vld_p0 && (starve_cnt >= STARVE_LIM)) begin
            axi_issue = 1'b1;
            vga_zero  = i_VGA_RD;
         end else if (i_VGA_RD) begin
            vga_issue = 1'b1;
            if (hold_vld_p0) starve_nxt = sat_inc(starve_cnt);
         end else begin
            axi_issue = hold_vld_p0;
         end
      end
      if (axi_issue) starve_nxt = '0;
   end

   // stage 0: AXI holding register
   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         hold_vld_p0 <= 1'b0;
         hold_wr_p0  <= 1'b0;
         starve_cnt  <= '0;
      end else begin
         starve_cnt <= starve_nxt;
         if (accept) begin
            hold_vld_p0 <= 1'b1;
            hold_wr_p0  <= i_AXI_WR;
         end else if (axi_issue) begin
            hold_vld_p0 <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_CLK) begin
      if (accept) begin
         hold_addr_p0  <= i_AXI_ADDR;
         hold_wdata_p0 <= i_AXI_WDATA;
      end
   end

   // stage 1: registered BRAM command plus return tag entry
   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         o_BRAM_RD    <= 1'b0;
         o_BRAM_WR    <= 1'b0;
         o_BRAM_ADDR  <= '0;
         o_BRAM_WDATA <= '0;
         o_AXI_WDONE  <= 1'b0;
         vld_axi_p    <= '0;
         vld_vga_p    <= '0;
         zero_vga_p   <= '0;
      end else begin
         o_BRAM_RD   <= vga_issue | (axi_issue & ~hold_wr_p0);
         o_BRAM_WR   <= axi_issue & hold_wr_p0;
         o_AXI_WDONE <= axi_issue & hold_wr_p0;
         if (vga_issue) begin
            o_BRAM_ADDR <= i_VGA_ADDR;
         end else if (axi_issue) begin
            o_BRAM_ADDR <= hold_addr_p0;
         end
         if (axi_issue & hold_wr_p0) o_BRAM_WDATA <= hold_wdata_p0;
         vld_axi_p  <= {vld_axi_p[RD_LAT-1:0], axi_issue & ~hold_wr_p0};
         vld_vga_p  <= {vld_vga_p[RD_LAT-1:0], vga_issue | vga_zero};
         zero_vga_p <= {zero_vga_p[RD_LAT-1:0], vga_zero};
      end
   end

   // stage RD_LAT+1: route BRAM data to the tagged requester
   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         o_AXI_RVALID <= 1'b0;
         o_AXI_RDATA  <= '0;
         o_VGA_RVALID <= 1'b0;
         o_VGA_RDATA  <= '0;
         o_VGA_MISS   <= 1'b0;
      end else begin
         o_AXI_RVALID <= vld_axi_p[RD_LAT];
         o_VGA_RVALID <= vld_vga_p[RD_LAT];
         o_VGA_MISS   <= vld_vga_p[RD_LAT] & zero_vga_p[RD_LAT] & DYN;
         if (vld_axi_p[RD_LAT]) o_AXI_RDATA <= i_BRAM_RDATA;
         if (vld_vga_p[RD_LAT]) o_VGA_RDATA <= zero_vga_p[RD_LAT] ? '0 : i_BRAM_RDATA;
      end
   end

endmodule
